// File: rtl/spikehard_dma_responder.sv
// DMA responder model: independent read and write stream engines sharing one
// beat-addressed memory, with a bench-side backdoor port for preload and inspection.
module spikehard_dma_responder #(
    parameter int unsigned DMA_BUS_WIDTH = 32,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter logic [2:0]  EXPECTED_SIZE = 3'b010
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dma_read_ctrl_valid,
    output logic                          dma_read_ctrl_ready,
    input  logic [31:0]                   dma_read_ctrl_data_index,
    input  logic [31:0]                   dma_read_ctrl_data_length,
    input  logic [2:0]                    dma_read_ctrl_data_size,
    output logic                          dma_read_chnl_valid,
    input  logic                          dma_read_chnl_ready,
    output logic [DMA_BUS_WIDTH-1:0]      dma_read_chnl_data,
    input  logic                          dma_write_ctrl_valid,
    output logic                          dma_write_ctrl_ready,
    input  logic [31:0]                   dma_write_ctrl_data_index,
    input  logic [31:0]                   dma_write_ctrl_data_length,
    input  logic [2:0]                    dma_write_ctrl_data_size,
    input  logic                          dma_write_chnl_valid,
    output logic                          dma_write_chnl_ready,
    input  logic [DMA_BUS_WIDTH-1:0]      dma_write_chnl_data,
    input  logic                          bench_we,
    input  logic [$clog2(MEM_WORDS)-1:0]  bench_addr,
    input  logic [DMA_BUS_WIDTH-1:0]      bench_wdata,
    output logic [DMA_BUS_WIDTH-1:0]      bench_rdata,
    output logic                          rd_txn_done,
    output logic                          wr_txn_done,
    output logic                          size_err
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic {R_IDLE, R_STREAM} rd_state_e;
    typedef enum logic {W_IDLE, W_STREAM} wr_state_e;

    logic [DMA_BUS_WIDTH-1:0] mem [MEM_WORDS];

    rd_state_e                rd_state_q, rd_state_d;
    logic [AW-1:0]            rptr_q, rptr_d, rptr_inc;
    logic [31:0]              rd_rem_q, rd_rem_d;
    logic [DMA_BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                     rd_done_q, rd_done_d;

    wr_state_e                wr_state_q, wr_state_d;
    logic [AW-1:0]            wptr_q, wptr_d;
    logic [31:0]              wr_rem_q, wr_rem_d;
    logic                     wr_done_q, wr_done_d;

    logic                     size_err_q, size_err_d;
    logic                     live_q;
    logic                     rd_ctrl_fire, wr_ctrl_fire, dma_we;
    logic                     unused_idx_bits;

    assign unused_idx_bits = ^{dma_read_ctrl_data_index[31:AW], dma_write_ctrl_data_index[31:AW]};

    // live_q holds the ctrl readies low until the first edge after reset release
    assign dma_read_ctrl_ready  = live_q && (rd_state_q == R_IDLE);
    assign dma_write_ctrl_ready = live_q && (wr_state_q == W_IDLE);
    assign dma_read_chnl_valid  = (rd_state_q == R_STREAM);
    assign dma_write_chnl_ready = (wr_state_q == W_STREAM);
    assign dma_read_chnl_data   = rdata_q;
    assign rd_txn_done          = rd_done_q;
    assign wr_txn_done          = wr_done_q;
    assign size_err             = size_err_q;
    assign bench_rdata          = mem[bench_addr];

    assign rd_ctrl_fire = dma_read_ctrl_valid && dma_read_ctrl_ready;
    assign wr_ctrl_fire = dma_write_ctrl_valid && dma_write_ctrl_ready;
    assign dma_we       = (wr_state_q == W_STREAM) && dma_write_chnl_valid;
    assign rptr_inc     = rptr_q + 1'b1;

    always_comb begin
        rd_state_d = rd_state_q;
        rptr_d     = rptr_q;
        rd_rem_d   = rd_rem_q;
        rdata_d    = rdata_q;
        rd_done_d  = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (rd_ctrl_fire) begin
                    if (dma_read_ctrl_data_length == 32'd0) begin
                        rd_done_d = 1'b1;
                    end else begin
                        rptr_d     = dma_read_ctrl_data_index[AW-1:0];
                        rd_rem_d   = dma_read_ctrl_data_length;
                        rdata_d    = mem[dma_read_ctrl_data_index[AW-1:0]];
                        rd_state_d = R_STREAM;
                    end
                end
            end
            R_STREAM: begin
                if (dma_read_chnl_ready) begin
                    rd_rem_d = rd_rem_q - 32'd1;
                    if (rd_rem_q == 32'd1) begin
                        rd_state_d = R_IDLE;
                        rd_done_d  = 1'b1;
                    end else begin
                        // Array read sees pre-edge contents, so a same-edge DMA write loses
                        rptr_d  = rptr_inc;
                        rdata_d = mem[rptr_inc];
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wptr_d     = wptr_q;
        wr_rem_d   = wr_rem_q;
        wr_done_d  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (wr_ctrl_fire) begin
                    if (dma_write_ctrl_data_length == 32'd0) begin
                        wr_done_d = 1'b1;
                    end else begin
                        wptr_d     = dma_write_ctrl_data_index[AW-1:0];
                        wr_rem_d   = dma_write_ctrl_data_length;
                        wr_state_d = W_STREAM;
                    end
                end
            end
            W_STREAM: begin
                if (dma_write_chnl_valid) begin
                    wptr_d   = wptr_q + 1'b1;
                    wr_rem_d = wr_rem_q - 32'd1;
                    if (wr_rem_q == 32'd1) begin
                        wr_state_d = W_IDLE;
                        wr_done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        size_err_d = size_err_q;
        if (rd_ctrl_fire && (dma_read_ctrl_data_size != EXPECTED_SIZE)) size_err_d = 1'b1;
        if (wr_ctrl_fire && (dma_write_ctrl_data_size != EXPECTED_SIZE)) size_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q     <= 1'b0;
            rd_state_q <= R_IDLE;
            rptr_q     <= '0;
            rd_rem_q   <= '0;
            rdata_q    <= '0;
            rd_done_q  <= 1'b0;
            wr_state_q <= W_IDLE;
            wptr_q     <= '0;
            wr_rem_q   <= '0;
            wr_done_q  <= 1'b0;
            size_err_q <= 1'b0;
        end else begin
            live_q     <= 1'b1;
            rd_state_q <= rd_state_d;
            rptr_q     <= rptr_d;
            rd_rem_q   <= rd_rem_d;
            rdata_q    <= rdata_d;
            rd_done_q  <= rd_done_d;
            wr_state_q <= wr_state_d;
            wptr_q     <= wptr_d;
            wr_rem_q   <= wr_rem_d;
            wr_done_q  <= wr_done_d;
            size_err_q <= size_err_d;
        end
    end

    // Later assignment wins: a DMA beat overrides a bench write to the same word
    always_ff @(posedge clk) begin
        if (bench_we) mem[bench_addr] <= bench_wdata;
        if (dma_we) mem[wptr_q] <= dma_write_chnl_data;
    end

endmodule
